muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the MIPS execute stage. It owns the HI/LO registers and runs mult/multu in 1 busy cycle. It runs div/divu on an internal radix-2 restoring divider, so no vendor divider IP is needed. It generates the pipeline stall for mult/div and mfhi/mflo interlocks, replacing the fixed stall-countdown approach.

---
 rtl/muldiv_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide sequencer with stall generation for the MIPS EX stage.
// Optional abort input is compiled in with `define MULDIV_FLUSH_EN.
module muldiv_sequencer #(
    parameter int DIV_ITER = 32,
    parameter int WIDTH    = 32
) (
    input  logic             clock,
    input  logic             resetn,
`ifdef MULDIV_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL    = 3'd1,
        S_DSETUP = 3'd2,
        S_DITER  = 3'd3,
        S_DFIX   = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem, r_quo, r_dvsr;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_q, r_neg_r, r_b_zero;
    logic               r_div_zero, r_dz_save;
    logic               r_done;

    logic               w_flush;
    logic               w_accept;
    logic               w_is_mul, w_is_div, w_is_mthi, w_is_mtlo, w_signed;
    logic               w_done_nxt;
    logic               w_in_div;
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_shift, w_diff;
    logic [WIDTH-1:0]   w_q_fix, w_r_fix;

`ifdef MULDIV_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_is_mul  = (op_code[2:1] == 2'b00);
    assign w_is_div  = (op_code[2:1] == 2'b01);
    assign w_is_mthi = (op_code == 3'b100);
    assign w_is_mtlo = (op_code == 3'b101);
    assign w_signed  = ~op_code[0];
    assign w_accept  = (r_state == S_IDLE) & op_valid & ~w_flush;
    assign w_in_div  = (r_state == S_DSETUP) | (r_state == S_DITER) | (r_state == S_DFIX);

    // Sign- or zero-extend to 2*WIDTH so one multiplier serves mult and multu.
    assign w_ext_a = {{WIDTH{w_signed & src_a[WIDTH-1]}}, src_a};
    assign w_ext_b = {{WIDTH{w_signed & src_b[WIDTH-1]}}, src_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_abs_a = (w_signed & src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
    assign w_abs_b = (w_signed & src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};

    assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
                else if (w_accept && w_is_div) w_state_nxt = S_DSETUP;
            end
            S_MUL: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            S_DSETUP: begin
                if (r_b_zero) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_DITER;
                end
            end
            S_DITER: begin
                if (r_cnt == '0) w_state_nxt = S_DFIX;
            end
            S_DFIX: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_flush) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_prod     <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_div_zero <= 1'b0;
            r_dz_save  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_accept) begin
                if (w_is_mthi) r_hi <= src_a;
                if (w_is_mtlo) r_lo <= src_a;
                if (w_is_mul)  r_prod <= w_prod;
                if (w_is_div) begin
                    r_dz_save  <= r_div_zero;
                    r_div_zero <= 1'b0;
                    r_quo      <= w_abs_a;
                    r_rem      <= '0;
                    r_dvsr     <= w_abs_b;
                    r_neg_q    <= w_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    r_neg_r    <= w_signed & src_a[WIDTH-1];
                    r_b_zero   <= (src_b == '0);
                end
            end
            if (w_flush) begin
                // An aborted divide leaves the flag as it was before that divide.
                if (w_in_div) r_div_zero <= r_dz_save;
            end else begin
                case (r_state)
                    S_MUL: {r_hi, r_lo} <= r_prod;
                    S_DSETUP: begin
                        if (r_b_zero) r_div_zero <= 1'b1;
                        else          r_cnt      <= CW'(DIV_ITER - 1);
                    end
                    S_DITER: begin
                        r_cnt <= r_cnt - 1'b1;
                        if (!w_diff[WIDTH]) begin
                            r_rem <= w_diff[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                    end
                    S_DFIX: begin
                        r_lo <= w_q_fix;
                        r_hi <= w_r_fix;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign stall    = busy & (op_valid | rd_hi | rd_lo);
    assign rd_data  = rd_hi ? r_hi : (rd_lo ? r_lo : '0);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized + directed bench for muldiv_sequencer against an arithmetic HI/LO model.
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        rd_hi = 1'b0, rd_lo = 1'b0;
    logic [31:0] rd_data, hi, lo;
    logic        stall, busy, done, div_zero;

    muldiv_sequencer #(.DIV_ITER(32), .WIDTH(32)) dut (
        .clock(clock), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
        .src_a(src_a), .src_b(src_b), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .rd_data(rd_data), .stall(stall), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Architectural effect of one instruction, from plain integer arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int exp_busy, output bit exp_done);
        logic [63:0] p;
        longint sa, sb, q, r;
        exp_busy = 0;
        exp_done = 0;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32]; m_lo = p[31:0]; exp_busy = 1; exp_done = 1;
            end
            3'd1: begin
                p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; exp_busy = 1; exp_done = 1;
            end
            3'd2, 3'd3: begin
                exp_done = 1;
                if (b == 32'h0) begin
                    m_dz = 1'b1; exp_busy = 1;
                end else begin
                    m_dz = 1'b0; exp_busy = 34;
                    if (op == 3'd2) begin
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'h0, a}); sb = longint'({32'h0, b});
                    end
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rh, input logic rl);
        logic [31:0] exp_rd;
        int          eb, n;
        bit          ed;
        exp_rd = rh ? m_hi : (rl ? m_lo : 32'h0);
        model_op(op, a, b, eb, ed);
        @(negedge clock);
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b; rd_hi = rh; rd_lo = rl;
        #1;
        chk("rd_pre_write", rd_data, exp_rd);
        chk("stall_idle", stall, 0);
        @(negedge clock);
        op_valid = 1'b0; rd_hi = 1'b0; rd_lo = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("busy_cycles", n, eb);
        chk("done", done, ed);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("div_zero", div_zero, m_dz);
        if (ed) begin
            @(negedge clock);
            chk("done_single", done, 0);
        end
    endtask

    initial begin
        int          n, bad, eb, dcnt;
        bit          ed;
        logic [2:0]  op;
        logic [31:0] a, b;

        repeat (3) @(negedge clock);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_stall", stall, 0);
        resetn = 1'b1;

        do_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        chk("mult_hi_const", hi, 32'hFFFFFFFF);
        do_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        chk("multu_hi_const", hi, 32'h00000002);
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        chk("div_lo_const", lo, 32'hFFFFFFFD);
        do_op(3'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        do_op(3'd4, 32'h11, 32'h0, 1'b0, 1'b0);
        do_op(3'd5, 32'h22, 32'h0, 1'b0, 1'b0);
        do_op(3'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        chk("dz_set", div_zero, 1);
        do_op(3'd2, 32'd6, 32'd3, 1'b0, 1'b0);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("ovf_lo_const", lo, 32'h80000000);
        do_op(3'd4, 32'hA5A5A5A5, 32'h0, 1'b1, 1'b0);
        do_op(3'd5, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b1);

        // Interlock: read and a second issue held during a divide.
        @(negedge clock);
        op_valid = 1'b1; op_code = 3'd2; src_a = 32'd1000; src_b = 32'd10;
        model_op(3'd2, 32'd1000, 32'd10, eb, ed);
        @(negedge clock);
        op_code = 3'd0; src_a = 32'd7; src_b = 32'hFFFFFFFD; rd_lo = 1'b1;
        n = 0; bad = 0;
        while (busy && n < 100) begin
            #1;
            if (!stall) bad++;
            n++;
            @(negedge clock);
        end
        #1;
        chk("intlk_busy", n, 34);
        chk("intlk_stall_hold", bad, 0);
        chk("intlk_done", done, 1);
        chk("intlk_rd", rd_data, 32'd100);
        chk("intlk_stall_free", stall, 0);
        model_op(3'd0, 32'd7, 32'hFFFFFFFD, eb, ed);
        @(negedge clock);
        op_valid = 1'b0; rd_lo = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("held_mul_busy", n, eb);
        chk("held_mul_hi", hi, m_hi);
        chk("held_mul_lo", lo, m_lo);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h80000000; b = 32'hFFFFFFFF;
            end
            do_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a divide.
        do_op(3'd4, 32'hDEAD0001, 32'h0, 1'b0, 1'b0);
        do_op(3'd5, 32'hBEEF0002, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        op_valid = 1'b1; op_code = 3'd2; src_a = 32'd12345; src_b = 32'd3;
        @(negedge clock);
        op_valid = 1'b0;
        repeat (11) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        chk("no_done_after_rst", dcnt, 0);
        chk("post_rst_hi", hi, m_hi);
        chk("post_rst_lo", lo, m_lo);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
